line_ram_responder: RTL and testbench
=====================================

Name: line_ram_responder

Overview:
- Memory-side responder for the cache simulator's RAM handshake (start / loadstore / mem_addr / data / mem_transaction_complete / mem_ready).
- Backs the 2048-line metadata store with on-chip block RAM and configurable latency, so the cache FSM runs without the DDR2 controller, in simulation or on the FPGA.
- Drop-in replacement at the cache's RAM interface; the cache logic sees identical handshake semantics.

Parameters:
INDEX_W, 11, number of line index bits; memory depth is 2^INDEX_W
ADDR_LSB, 17, bit position of the index LSB within mem_addr
DATA_W, 64, line width
LATENCY, 4, cycles from start acceptance to complete assertion; legal range 1..255
READY_DELAY, 16, cycles after reset release before mem_ready rises; legal range 1..65535

Ports:
clk  in  1  single clock
rst  in  1  asynchronous active-high reset
start  in  1  request; held high by the initiator until complete is seen
loadstore  in  1  1 = write, 0 = read
mem_addr  in  28  byte-style address; the index is mem_addr[ADDR_LSB+INDEX_W-1:ADDR_LSB]
mem_d_to_ram  in  DATA_W  write data
mem_d_from_ram  out  DATA_W  read data
mem_transaction_complete  out  1  transaction done; level signal
mem_ready  out  1  responder initialised
addr_err  out  1  sticky; an accepted address had a nonzero bit outside the index field
read_count  out  32  completed reads
write_count  out  32  completed writes

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to WARMUP.
  - All outputs go to 0: mem_ready, mem_transaction_complete, mem_d_from_ram, addr_err, read_count, write_count.
  - Memory contents are not reset; they are initialised to 0 at configuration only.
- States:
  - WARMUP: counter counts READY_DELAY cycles, then mem_ready is registered to 1 and the FSM goes to IDLE. mem_ready stays 1 until the next reset. Start is ignored in WARMUP.
  - IDLE: on an edge where start=1, accept the request:
    - latch loadstore, index and mem_d_to_ram;
    - set addr_err if any mem_addr bit outside the index field is 1;
    - load the latency counter with LATENCY-1;
    - go to BUSY.
  - BUSY: decrement the counter. On the edge where the counter is 0, perform the transaction and go to DONE:
    - read: mem_d_from_ram <= mem[index], read_count +1;
    - write: mem[index] <= latched data, write_count +1;
    - mem_transaction_complete <= 1 on the same edge.
  - DONE: complete stays 1 while start=1. On the edge where start=0 is sampled, complete <= 0 and the FSM goes to IDLE.
- Timing:
  - If acceptance is at edge E0, complete is high after edge E0+LATENCY.
  - A new request can be accepted no earlier than the edge after complete falls, so complete is low for at least one cycle between transactions.
- Inputs sampled after acceptance are ignored: changes to loadstore, mem_addr or data during BUSY/DONE have no effect.
- mem_d_from_ram changes only on read completion. It holds its value across writes and idle periods.
- Protocol violations:
  - Start dropped during BUSY: the transaction still completes. Complete is high for exactly one cycle if start is still 0 in DONE.
  - Start high continuously through DONE and IDLE: this is a new request. It is accepted on the first IDLE edge after complete has fallen, which requires start to have been sampled low once in DONE.
- Reset mid-transaction: the pending write is dropped with no partial update, counts are cleared, and the FSM re-enters WARMUP.
- Counters wrap at 2^32 with no saturation.
- Read-after-write to the same index returns the newly written data; the write commits to memory before the read's later completion edge.
- Memory is inferred as single-port synchronous block RAM: one access per transaction, at completion.

Test Plan:
- Reset then idle: rst released at cycle 0 with READY_DELAY=16 -> mem_ready=0 through cycle 15 and 1 from cycle 16 onward; complete=0; both counts=0.
- Write then read: write index 5 (mem_addr=28'h00A0000) with data 64'hDEADBEEF_0123A5A5, then read the same address -> read returns that data; complete rises exactly 4 cycles after each acceptance; write_count=1, read_count=1, addr_err=0.
- Four-phase hold: initiator holds start for 10 cycles after complete -> complete stays high for all 10 cycles and falls on the edge after start is sampled 0; no second access occurs.
- Full sweep: write index i with data i for i=0..2047, then read all 2047..0 -> every read matches; write_count=2048, read_count=2048; the index wraps with no aliasing.
- Address error and input change: accept a request with mem_addr=28'h0000001, then change mem_addr during BUSY -> addr_err=1 and stays sticky; the access targets index 0.
- Reset mid-write: rst asserted during BUSY of a write to index 7 that previously held 64'h1 -> after re-warmup a read of index 7 returns 64'h1; counters restart from 0.

Source files
------------

// File: rtl/line_ram_responder.sv
// Block-RAM backed responder for the cache RAM handshake (start / complete / ready).
// Fixed-latency access, one memory touch per transaction, performed at completion.
module line_ram_responder #(
   parameter int INDEX_W     = 11,
   parameter int ADDR_LSB    = 17,
   parameter int DATA_W      = 64,
   parameter int LATENCY     = 4,
   parameter int READY_DELAY = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              loadstore,
   input  logic [27:0]       mem_addr,
   input  logic [DATA_W-1:0] mem_d_to_ram,
   output logic [DATA_W-1:0] mem_d_from_ram,
   output logic              mem_transaction_complete,
   output logic              mem_ready,
   output logic              addr_err,
   output logic [31:0]       read_count,
   output logic [31:0]       write_count
);

   localparam int DEPTH = 1 << INDEX_W;
   localparam logic [27:0] IDX_MASK = ((28'(1) << INDEX_W) - 28'(1)) << ADDR_LSB;

   typedef enum logic [1:0] {WARMUP, IDLE, BUSY, DONE} state_t;

   state_t              state, state_nx;
   logic [15:0]         warm_cnt;
   logic [7:0]          lat_cnt;
   logic                ls_q;
   logic [INDEX_W-1:0]  idx_q;
   logic [DATA_W-1:0]   wdata_q;

   // Contents come up as zero at configuration and are never touched by reset.
   logic [DATA_W-1:0]   mem [0:DEPTH-1] = '{default: '0};

   logic warm_done, accept, fire, release_done;

   assign warm_done    = (state == WARMUP) && (warm_cnt == 16'(READY_DELAY - 1));
   assign accept       = (state == IDLE) && start;
   assign fire         = (state == BUSY) && (lat_cnt == 8'd0);
   assign release_done = (state == DONE) && !start;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= WARMUP;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         WARMUP:  if (warm_done)    state_nx = IDLE;
         IDLE:    if (accept)       state_nx = BUSY;
         BUSY:    if (fire)         state_nx = DONE;
         DONE:    if (release_done) state_nx = IDLE;
         default:                   state_nx = WARMUP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         warm_cnt                 <= '0;
         mem_ready                <= 1'b0;
         lat_cnt                  <= '0;
         ls_q                     <= 1'b0;
         idx_q                    <= '0;
         wdata_q                  <= '0;
         addr_err                 <= 1'b0;
         mem_transaction_complete <= 1'b0;
         mem_d_from_ram           <= '0;
         read_count               <= '0;
         write_count              <= '0;
      end else begin
         if (state == WARMUP && !warm_done) warm_cnt <= warm_cnt + 16'd1;
         if (warm_done) mem_ready <= 1'b1;

         // Request fields are captured once; later input changes are ignored.
         if (accept) begin
            ls_q    <= loadstore;
            idx_q   <= mem_addr[ADDR_LSB +: INDEX_W];
            wdata_q <= mem_d_to_ram;
            lat_cnt <= 8'(LATENCY - 1);
            if ((mem_addr & ~IDX_MASK) != 28'd0) addr_err <= 1'b1;
         end

         if (state == BUSY && !fire) lat_cnt <= lat_cnt - 8'd1;

         if (fire) begin
            mem_transaction_complete <= 1'b1;
            if (ls_q) write_count <= write_count + 32'd1;
            else begin
               read_count     <= read_count + 32'd1;
               mem_d_from_ram <= mem[idx_q];
            end
         end

         if (release_done) mem_transaction_complete <= 1'b0;
      end
   end

   // Write port kept reset-free so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (fire && ls_q) mem[idx_q] <= wdata_q;
   end

endmodule

// File: tb/tb_line_ram_responder.sv
// Directed bench for line_ram_responder: warmup, handshake timing, sweep, errors, reset.
module tb_line_ram_responder;

   localparam int LAT = 4;
   localparam int RDY = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        loadstore;
   logic [27:0] mem_addr;
   logic [63:0] mem_d_to_ram;
   logic [63:0] mem_d_from_ram;
   logic        mem_transaction_complete;
   logic        mem_ready;
   logic        addr_err;
   logic [31:0] read_count;
   logic [31:0] write_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   line_ram_responder #(
      .INDEX_W(11), .ADDR_LSB(17), .DATA_W(64), .LATENCY(LAT), .READY_DELAY(RDY)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .loadstore(loadstore),
      .mem_addr(mem_addr), .mem_d_to_ram(mem_d_to_ram),
      .mem_d_from_ram(mem_d_from_ram),
      .mem_transaction_complete(mem_transaction_complete),
      .mem_ready(mem_ready), .addr_err(addr_err),
      .read_count(read_count), .write_count(write_count)
   );

   // Drive one request; lat = negedges from request until complete seen
   // (acceptance edge plus LAT), rd = read data after start released.
   task automatic run_txn(input logic ls, input logic [27:0] addr, input logic [63:0] d,
                          output int lat, output logic [63:0] rd, output logic cpl_after);
      @(negedge clk);
      start = 1'b1; loadstore = ls; mem_addr = addr; mem_d_to_ram = d;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!mem_transaction_complete && lat < 40);
      start = 1'b0;
      @(negedge clk);
      rd = mem_d_from_ram;
      cpl_after = mem_transaction_complete;
   endtask

   task automatic wait_ready(output logic ok);
      int n = 0;
      while (!mem_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = mem_ready;
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; loadstore = 1'b0; mem_addr = '0; mem_d_to_ram = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         checks++;
         if (mem_ready !== (k >= RDY)) begin
            errors++;
            $display("FAIL reset_ready cycle %0d: got %b want %b", k, mem_ready, (k >= RDY));
         end
      end
      checks++;
      if ({mem_transaction_complete, addr_err, read_count, write_count, mem_d_from_ram} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: cpl=%b err=%b rc=%0d wc=%0d rd=%h want all 0",
                  mem_transaction_complete, addr_err, read_count, write_count, mem_d_from_ram);
      end
   endtask

   task automatic test_write_read;
      int lat; logic [63:0] rd; logic c;
      run_txn(1'b1, 28'h00A0000, 64'hDEADBEEF_0123A5A5, lat, rd, c);
      checks++;
      if (lat - 1 !== LAT) begin errors++; $display("FAIL wr_latency: got %0d want %0d", lat - 1, LAT); end
      checks++;
      if (c !== 1'b0) begin errors++; $display("FAIL wr_cpl_fall: got %b want 0", c); end
      checks++;
      if (rd !== 64'h0) begin errors++; $display("FAIL wr_no_rd_change: got %h want 0", rd); end
      run_txn(1'b0, 28'h00A0000, 64'h0, lat, rd, c);
      checks++;
      if (lat - 1 !== LAT) begin errors++; $display("FAIL rd_latency: got %0d want %0d", lat - 1, LAT); end
      checks++;
      if (rd !== 64'hDEADBEEF_0123A5A5) begin
         errors++; $display("FAIL rd_data: got %h want DEADBEEF0123A5A5", rd);
      end
      checks++;
      if ({write_count, read_count, addr_err} !== {32'd1, 32'd1, 1'b0}) begin
         errors++; $display("FAIL wr_rd_counts: wc=%0d rc=%0d err=%b want 1 1 0", write_count, read_count, addr_err);
      end
   endtask

   task automatic test_hold;
      int n = 0; int low_seen = 0;
      @(negedge clk);
      start = 1'b1; loadstore = 1'b1; mem_addr = 28'(9) << 17; mem_d_to_ram = 64'h99;
      while (!mem_transaction_complete && n < 40) begin @(negedge clk); n++; end
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (!mem_transaction_complete) low_seen++;
      end
      checks++;
      if (low_seen !== 0) begin errors++; $display("FAIL hold_cpl: low %0d of 10 cycles, want 0", low_seen); end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_transaction_complete !== 1'b0) begin errors++; $display("FAIL hold_fall: got 1 want 0"); end
      repeat (LAT + 2) @(negedge clk);
      checks++;
      if (write_count !== 32'd2 || mem_transaction_complete !== 1'b0) begin
         errors++; $display("FAIL hold_single_access: wc=%0d cpl=%b want 2 0", write_count, mem_transaction_complete);
      end
   endtask

   task automatic test_sweep;
      int lat; logic [63:0] rd; logic c; int bad = 0;
      logic [31:0] wc0, rc0;
      wc0 = write_count; rc0 = read_count;
      for (int i = 0; i < 2048; i++) run_txn(1'b1, 28'(i) << 17, 64'(i), lat, rd, c);
      for (int i = 2047; i >= 0; i--) begin
         run_txn(1'b0, 28'(i) << 17, 64'h0, lat, rd, c);
         if (rd !== 64'(i)) begin
            bad++;
            if (bad < 4) $display("FAIL sweep_rd idx %0d: got %h want %h", i, rd, 64'(i));
         end
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL sweep_total: %0d bad reads want 0", bad); end
      checks++;
      if (write_count - wc0 !== 32'd2048 || read_count - rc0 !== 32'd2048) begin
         errors++; $display("FAIL sweep_counts: dw=%0d dr=%0d want 2048 2048", write_count - wc0, read_count - rc0);
      end
   endtask

   task automatic test_addr_err;
      int n = 0; int lat; logic [63:0] rd; logic c;
      logic [31:0] wc0, rc0;
      wc0 = write_count; rc0 = read_count;
      @(negedge clk);
      start = 1'b1; loadstore = 1'b0; mem_addr = 28'h0000001; mem_d_to_ram = 64'h55;
      @(negedge clk);
      mem_addr = 28'(7) << 17; loadstore = 1'b1;
      while (!mem_transaction_complete && n < 40) begin @(negedge clk); n++; end
      start = 1'b0;
      @(negedge clk);
      checks++;
      if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_set: got %b want 1", addr_err); end
      checks++;
      if (mem_d_from_ram !== 64'h0 || read_count - rc0 !== 32'd1 || write_count !== wc0) begin
         errors++; $display("FAIL addr_latched: rd=%h dr=%0d dw=%0d want 0 1 0",
                            mem_d_from_ram, read_count - rc0, write_count - wc0);
      end
      run_txn(1'b0, 28'(7) << 17, 64'h0, lat, rd, c);
      checks++;
      if (addr_err !== 1'b1 || rd !== 64'h7) begin
         errors++; $display("FAIL addr_err_sticky: err=%b rd=%h want 1 7", addr_err, rd);
      end
   endtask

   task automatic test_reset_mid_write;
      int lat; logic [63:0] rd; logic c; logic ok;
      run_txn(1'b1, 28'(7) << 17, 64'h1, lat, rd, c);
      @(negedge clk);
      start = 1'b1; loadstore = 1'b1; mem_addr = 28'(7) << 17; mem_d_to_ram = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (2) @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      checks++;
      if ({mem_ready, mem_transaction_complete, addr_err, read_count, write_count, mem_d_from_ram} !== '0) begin
         errors++; $display("FAIL midrst_clear: rdy=%b cpl=%b err=%b rc=%0d wc=%0d want all 0",
                            mem_ready, mem_transaction_complete, addr_err, read_count, write_count);
      end
      rst = 1'b0;
      wait_ready(ok);
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b want 1", ok); end
      run_txn(1'b0, 28'(7) << 17, 64'h0, lat, rd, c);
      checks++;
      if (rd !== 64'h1) begin errors++; $display("FAIL midrst_data: got %h want 1", rd); end
      checks++;
      if (read_count !== 32'd1 || write_count !== 32'd0) begin
         errors++; $display("FAIL midrst_counts: rc=%0d wc=%0d want 1 0", read_count, write_count);
      end
   endtask

   initial begin
      test_reset;
      test_write_read;
      test_hold;
      test_sweep;
      test_addr_err;
      test_reset_mid_write;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
